load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage front end between the EX/MEM pipeline and data_mem. Accepts one load/store
//  request per handshake, drives the word-only data_mem port, and implements sub-word
//  stores by read-modify-write. Loads are sign/zero-extended per funct3 and returned
//  with the destination register for the WB stage.
// PARAMETERS
//  WIDTH    32  data/address width; all_pkgs value, fixed at 32 for RV32I.
//  RD_W     5   destination register index width.
// PORTS
//  clk          in   1      clock; all state updates on posedge.
//  rst          in   1      synchronous reset, active-high.
//  req_valid    in   1      request present.
//  req_ready    out  1      LSU can accept; high only in IDLE.
//  req_load     in   1      request is a load.
//  req_store    in   1      request is a store.
//  req_funct3   in   3      RV32I size/sign code.
//  req_addr     in   WIDTH  byte address.
//  req_wdata    in   WIDTH  store data; low bits used for SB/SH.
//  req_rd       in   RD_W   load destination register.
//  mem_rd_en    out  1      to data_mem.
//  mem_wr_en    out  1      to data_mem.
//  mem_addr     out  WIDTH  to data_mem; always req_addr with [1:0] forced to 0.
//  mem_wr_data  out  WIDTH  to data_mem.
//  mem_rd_data  in   WIDTH  from data_mem; combinational read.
//  resp_valid   out  1      one-cycle completion pulse.
//  resp_data    out  WIDTH  extended load data; 0 for stores/errors.
//  resp_rd      out  RD_W   destination register.
//  resp_wb_en   out  1      write back: load, no error, resp_rd != 0.
//  resp_err     out  1      request not performed.
// BEHAVIOUR
//  - Reset: state=IDLE, all resp_* = 0, mem_rd_en = mem_wr_en = 0, latched request cleared.
//  - Reset mid-operation abandons the request. No memory write in or after the reset cycle.
//  - IDLE: req_ready = 1. On req_valid, latch the request and go to ACCESS.
//  - ACCESS, load codes 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU:
//    - mem_rd_en = 1.
//    - Register the extracted lane: byte lane addr[1:0], half lane addr[1].
//    - Sign-extend LB/LH; zero-extend LBU/LHU.
//    - Go to IDLE and pulse resp_valid on the next cycle.
//  - ACCESS, SW (010): mem_wr_en = 1, mem_wr_data = req_wdata. Go to IDLE; resp_valid next cycle.
//  - ACCESS, SB (000) / SH (001): mem_rd_en = 1, capture mem_rd_data into merge_q, go to MERGE.
//  - MERGE:
//    - mem_wr_en = 1.
//    - mem_wr_data = merge_q with the addressed byte/half replaced by req_wdata[7:0] / [15:0].
//    - Go to IDLE; resp_valid next cycle.
//  - Illegal requests: load&store both set, neither set, or an undefined funct3.
//    - ACCESS performs no memory access.
//    - resp_err = 1, resp_wb_en = 0.
//  - Latency, accept edge T: LW/LB/LH/SW complete with resp_valid at T+2; SB/SH at T+3.
//  - Throughput: one request per 2 cycles (3 for SB/SH). No new accept until back in IDLE.
//  - mem_rd_en and mem_wr_en are never high together. Both are 0 in IDLE.
//  - resp_* are registered. resp_valid is high exactly one cycle per accepted request.
//    Other resp_* fields hold their value until the next response.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - Halfword with addr[0] = 1 or word with addr[1:0] != 0 is illegal.
//    - No memory access; resp_err = 1.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - No misalignment error.
//    - Halfword uses addr[1] only; word ignores addr[1:0].
// TESTING
//  - SW addr 0x10, data 0xDEADBEEF, then LW 0x10:
//    - Write seen at T+1.
//    - LW resp_data = 0xDEADBEEF, resp_wb_en = 1, resp_valid at T+2.
//  - Word 0x10 = 0x00000000, SB addr 0x12, wdata 0x1234_56A5:
//    - Read in ACCESS, write 0x00A50000 in MERGE, resp_valid at T+3.
//    - Then LB 0x12 -> 0xFFFFFFA5; LBU 0x12 -> 0x000000A5.
//  - Word 0x20 = 0x8001_7FFF:
//    - LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x20 -> 0x00007FFF.
//  - Load with req_rd = 0 -> resp_wb_en = 0. Funct3 011 load -> resp_err = 1, no mem_rd_en.
//  - Assert rst in the MERGE cycle of an SB:
//    - No mem_wr_en after rst, memory word unchanged.
//    - resp_valid = 0, req_ready = 1 the cycle after reset releases.
//  - LW addr 0x13:
//    - With LSU_MISALIGN_TRAP_EN: resp_err = 1, no access.
//    - Without it: data of word 0x10 returned.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, data-memory and response bundle for the load/store unit
interface load_store_unit_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [RD_W-1:0]  req_rd;
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wr_data;
    logic [WIDTH-1:0] mem_rd_data;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic [RD_W-1:0]  resp_rd;
    logic             resp_wb_en;
    logic             resp_err;

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rd_data,
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               resp_valid, resp_data, resp_rd, resp_wb_en, resp_err
    );

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd, mem_rd_data,
        output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               resp_valid, resp_data, resp_rd, resp_wb_en, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store front end with read-modify-write sub-word stores
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses
module load_store_unit #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

    state_t           state, state_n;
    logic             ld_q, st_q;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q, wdata_q, merge_q;
    logic [RD_W-1:0]  rd_q;
    logic             legal, misal, ok, sub_st, done;
    logic [4:0]       sh;
    logic [WIDTH-1:0] lane, load_val, mask, merged;

    // Decode the latched request, extract/extend load lanes and build the merged store word
    always_comb begin
        legal = (ld_q != st_q) && (ld_q ? (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                        : (f3_q inside {3'b000, 3'b001, 3'b010}));
`ifdef LSU_MISALIGN_TRAP_EN
        misal = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        ok       = legal && !misal;
        sub_st   = ok && st_q && f3_q[1:0] != 2'b10;
        sh       = f3_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
        lane     = bus.mem_rd_data >> sh;
        load_val = f3_q[1] ? bus.mem_rd_data
                 : f3_q[0] ? {{(WIDTH-16){!f3_q[2] && lane[15]}}, lane[15:0]}
                           : {{(WIDTH-8){!f3_q[2] && lane[7]}}, lane[7:0]};
        mask     = (f3_q[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF)) << sh;
        merged   = (merge_q & ~mask) | ((wdata_q << sh) & mask);
        done     = (state == ACCESS && !sub_st) || state == MERGE;
        bus.req_ready   = state == IDLE;
        bus.mem_addr    = {addr_q[WIDTH-1:2], 2'b00};
        bus.mem_rd_en   = !rst && state == ACCESS && ok && (ld_q || sub_st);
        bus.mem_wr_en   = !rst && ((state == ACCESS && ok && st_q && !sub_st) || state == MERGE);
        bus.mem_wr_data = state == MERGE ? merged : wdata_q;
        state_n = state == IDLE ? (bus.req_valid ? ACCESS : IDLE)
                : (state == ACCESS && sub_st) ? MERGE : IDLE;
    end

    // State register, request latch, merge buffer and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ld_q           <= 1'b0;
            st_q           <= 1'b0;
            f3_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            merge_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_rd    <= '0;
            bus.resp_wb_en <= 1'b0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_n;
            bus.resp_valid <= done;
            if (state == IDLE && bus.req_valid) begin
                ld_q    <= bus.req_load;
                st_q    <= bus.req_store;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end
            if (state == ACCESS && sub_st)
                merge_q <= bus.mem_rd_data;
            if (done) begin
                bus.resp_data  <= (ld_q && ok) ? load_val : '0;
                bus.resp_rd    <= rd_q;
                bus.resp_err   <= !ok;
                bus.resp_wb_en <= ld_q && ok && rd_q != '0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a word-wide memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.WIDTH(32), .RD_W(5)) bus ();

    load_store_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [31:0] mem [64];
    int writes = 0;
    int overlap = 0;

    // Word-wide data memory: combinational read, write on posedge
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
            writes <= writes + 1;
        end
    end

    assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];

    // Read and write enables must never be high together
    always @(negedge clk) begin
        if (bus.mem_rd_en && bus.mem_wr_en) overlap <= overlap + 1;
    end

    int nchk = 0;
    int nerr = 0;
    int lat, wr_cyc, w0;
    logic rd_any;
    logic [31:0] wr_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        check("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        wr_cyc = 0;
        rd_any = 1'b0;
        wr_d = 32'h0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en) begin
                wr_cyc = i;
                wr_d = bus.mem_wr_data;
            end
            if (bus.mem_rd_en) rd_any = 1'b1;
            if (bus.resp_valid) lat = i;
        end
        if (lat == 0) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
        req(1'b1, 1'b0, f3, a, 32'h0, 5'd9);
        check({tag, "_data"}, bus.resp_data, exp);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_err"}, 32'(bus.resp_err), 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_data", bus.resp_data, 32'h0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_en", {30'b0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
        rst = 1'b0;

        req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_wcyc", 32'(wr_cyc), 32'd1);
        check("sw_wdata", wr_d, 32'hDEADBEEF);
        check("sw_rdata", bus.resp_data, 32'h0);
        check("sw_wb", 32'(bus.resp_wb_en), 32'd0);

        req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        check("lw_data", bus.resp_data, 32'hDEADBEEF);
        check("lw_wb", 32'(bus.resp_wb_en), 32'd1);
        check("lw_rd", 32'(bus.resp_rd), 32'd5);
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_rden", 32'(rd_any), 32'd1);
        @(negedge clk);
        check("pulse_low", 32'(bus.resp_valid), 32'd0);
        check("data_hold", bus.resp_data, 32'hDEADBEEF);

        req(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 5'd0);
        req(1'b0, 1'b1, 3'b010, 32'h20, 32'h80017FFF, 5'd0);
        req(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 5'd0);

        req(1'b0, 1'b1, 3'b000, 32'h12, 32'h123456A5, 5'd0);
        check("sb_lat", 32'(lat), 32'd3);
        check("sb_wcyc", 32'(wr_cyc), 32'd2);
        check("sb_wdata", wr_d, 32'h00A50000);
        check("sb_rden", 32'(rd_any), 32'd1);
        check("sb_err", 32'(bus.resp_err), 32'd0);

        load("lb", 3'b000, 32'h12, 32'hFFFFFFA5);
        load("lbu", 3'b100, 32'h12, 32'h000000A5);
        load("lh_hi", 3'b001, 32'h22, 32'hFFFF8001);
        load("lhu_hi", 3'b101, 32'h22, 32'h00008001);
        load("lh_lo", 3'b001, 32'h20, 32'h00007FFF);

        req(1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF1234, 5'd0);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_wdata", wr_d, 32'h12347FFF);
        load("lw_after_sh", 3'b010, 32'h20, 32'h12347FFF);

        req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd0);
        check("rd0_wb", 32'(bus.resp_wb_en), 32'd0);
        check("rd0_data", bus.resp_data, 32'h12347FFF);

        req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd4);
        check("f3_err", 32'(bus.resp_err), 32'd1);
        check("f3_rden", 32'(rd_any), 32'd0);
        check("f3_wb", 32'(bus.resp_wb_en), 32'd0);
        check("f3_data", bus.resp_data, 32'h0);
        check("f3_lat", 32'(lat), 32'd2);

        req(1'b1, 1'b1, 3'b010, 32'h10, 32'h5555AAAA, 5'd4);
        check("both_err", 32'(bus.resp_err), 32'd1);
        check("both_wr", 32'(wr_cyc), 32'd0);
        req(1'b0, 1'b0, 3'b010, 32'h10, 32'h5555AAAA, 5'd4);
        check("none_err", 32'(bus.resp_err), 32'd1);
        check("none_acc", {31'b0, rd_any} | 32'(wr_cyc), 32'd0);
        req(1'b0, 1'b1, 3'b100, 32'h10, 32'h5555AAAA, 5'd0);
        check("sbad_err", 32'(bus.resp_err), 32'd1);
        check("sbad_wr", 32'(wr_cyc), 32'd0);

        w0 = writes;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h31;
        bus.req_wdata  = 32'h00000099;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstm_wren", 32'(bus.mem_wr_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstm_valid", 32'(bus.resp_valid), 32'd0);
        check("rstm_ready", 32'(bus.req_ready), 32'd1);
        check("rstm_wren2", 32'(bus.mem_wr_en), 32'd0);
        check("rstm_mem", mem[12], 32'h11223344);
        check("rstm_writes", 32'(writes), 32'(w0));

        req(1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 5'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lw_err", 32'(bus.resp_err), 32'd1);
        check("mis_lw_rden", 32'(rd_any), 32'd0);
        check("mis_lw_data", bus.resp_data, 32'h0);
`else
        check("mis_lw_err", 32'(bus.resp_err), 32'd0);
        check("mis_lw_data", bus.resp_data, 32'h00A50000);
`endif
        req(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 5'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lh_err", 32'(bus.resp_err), 32'd1);
        check("mis_lh_wb", 32'(bus.resp_wb_en), 32'd0);
`else
        check("mis_lh_err", 32'(bus.resp_err), 32'd0);
        check("mis_lh_data", bus.resp_data, 32'h00007FFF);
`endif

        check("rd_wr_overlap", 32'(overlap), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
